alu_seq: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 62 ++++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state types for the sequential ALU.
package alu_pkg;

    // Opcode encoding presented on the op input. Codes 10..15 are undefined.
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        NOT = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7,
        ASR = 4'd8,
        MUL = 4'd9
    } alu_op_e;

    // Handshake FSM states. Prefixed so they do not collide with the opcode MUL.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// WIDTH steps after start. done is high during the cycle whose rising edge
// performs the final step, and product then shows the value that edge yields,
// so the owner can register the finished product on that same edge.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     step;
    logic [2*WIDTH-1:0] acc_nxt;

    // Accumulate the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    assign done    = busy && (step == LAST_STEP);
    assign product = acc_nxt;

    // Load operands on start, then perform one shift-add step per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            step   <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            step   <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 1'b1;
            if (step == LAST_STEP) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes. Single-cycle arithmetic, logic
// and shift ops; unsigned multiply is delegated to alu_mul_seq.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; a/b/op are captured on the accepting
// edge and ignored afterwards. out_valid, result and flags stay constant from
// the edge they are registered until the edge on which out_ready is seen high;
// in_ready returns the cycle after that output transfer.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     ext;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   r_c;
    logic               c_c;
    logic               v_c;

    assign in_ready = (state == S_IDLE) && !mul_busy;
    assign accept   = in_valid && in_ready;
    assign is_mul   = (alu_op_e'(op) == MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result, carry and overflow from the live operands.
    // Shifts carry one extra bit so the last bit shifted out lands in it.
    always_comb begin
        sum = '0;
        ext = '0;
        sh  = b[SHW-1:0];
        r_c = '0;
        c_c = 1'b0;
        v_c = 1'b0;
        case (alu_op_e'(op))
            ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r_c = sum[WIDTH-1:0];
                c_c = sum[WIDTH];
                v_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r_c = sum[WIDTH-1:0];
                c_c = sum[WIDTH];
                v_c = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            AND: r_c = a & b;
            OR:  r_c = a | b;
            XOR: r_c = a ^ b;
            NOT: r_c = ~b;
            SHL: begin
                ext = {1'b0, a} << sh;
                r_c = ext[WIDTH-1:0];
                c_c = ext[WIDTH];
            end
            SHR: begin
                ext = {a, 1'b0} >> sh;
                r_c = ext[WIDTH:1];
                c_c = ext[0];
            end
            ASR: begin
                ext = $signed({a, 1'b0}) >>> sh;
                r_c = ext[WIDTH:1];
                c_c = ext[0];
            end
            default: begin
                // MUL is handled by the multiplier; undefined codes yield zero.
                r_c = '0;
            end
        endcase
    end

    // Handshake FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= S_MUL;
                        end else begin
                            result    <= r_c;
                            flag_n    <= r_c[WIDTH-1];
                            flag_z    <= (r_c == '0);
                            flag_c    <= c_c;
                            flag_v    <= v_c;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        result    <= mul_product[WIDTH-1:0];
                        flag_n    <= mul_product[WIDTH-1];
                        flag_z    <= (mul_product[WIDTH-1:0] == '0);
                        flag_c    <= |mul_product[2*WIDTH-1:WIDTH];
                        flag_v    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, output back-pressure,
// reset during a multiply, then randomized operations against a reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W   = 16;
    localparam int SHW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries are {result, n, z, c, v}.
    logic [W+3:0] exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux, uy, p;
        longint sx, sy, sr;
        int     s;
        logic [W-1:0] r;
        logic c, v;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s  = int'(y[SHW-1:0]);
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            4'd0: begin
                p  = ux + uy;
                r  = W'(p);
                c  = (p >= (64'sd1 << W));
                sr = sx + sy;
                v  = (sr > (64'sd1 << (W-1)) - 1) || (sr < -(64'sd1 << (W-1)));
            end
            4'd1: begin
                r  = W'(ux - uy);
                c  = (ux >= uy);
                sr = sx - sy;
                v  = (sr > (64'sd1 << (W-1)) - 1) || (sr < -(64'sd1 << (W-1)));
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~y;
            4'd6: begin
                r = W'(ux << s);
                c = (s != 0) ? 1'(ux >> (W - s)) : 1'b0;
            end
            4'd7: begin
                r = W'(ux >> s);
                c = (s != 0) ? 1'(ux >> (s - 1)) : 1'b0;
            end
            4'd8: begin
                r = W'(sx >>> s);
                c = (s != 0) ? 1'(sx >>> (s - 1)) : 1'b0;
            end
            4'd9: begin
                p = ux * uy;
                r = W'(p);
                c = ((p >> W) != 0);
            end
            default: r = '0;
        endcase
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    // Present one operation and hold it until accepted; scramble inputs afterwards.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // Wait for the result, compare against the scoreboard, hold back-pressure, then accept it.
    task automatic recv(input int exp_lat, input int hold);
        int lat = 0;
        logic [W+3:0] e;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", 32'(result), 32'(e[W+3:4]));
            check("flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'(e[3:0]));
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", 32'(result), 32'(e[W+3:4]));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_hs", 32'(out_valid), 32'd0);
        check("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;

    vec_t dirs[8];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases with hand-computed results, flags = {n,z,c,v}
        dirs[0] = '{4'(ADD), 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
        dirs[1] = '{4'(SUB), 16'h0003, 16'h0005, 16'hFFFE, 4'b1000};
        dirs[2] = '{4'(SUB), 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
        dirs[3] = '{4'(MUL), 16'h00FF, 16'h0003, 16'h02FD, 4'b0000};
        dirs[4] = '{4'(MUL), 16'h0100, 16'h0100, 16'h0000, 4'b0110};
        dirs[5] = '{4'(SHL), 16'h8001, 16'h0001, 16'h0002, 4'b0010};
        dirs[6] = '{4'(ASR), 16'h8000, 16'h000F, 16'hFFFF, 4'b1000};
        dirs[7] = '{4'hF,    16'h1234, 16'h5678, 16'h0000, 4'b0100};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({dirs[i].r, dirs[i].f});
            send(dirs[i].o, dirs[i].x, dirs[i].y);
            recv((dirs[i].o == 4'(MUL)) ? W : 0, 1);
        end

        // Back-pressure with a second op waiting on in_valid
        send(4'(ADD), 16'h1111, 16'h2222);
        check("bp_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 4'(SUB);
        a         = 16'h0005;
        b         = 16'h0003;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(result), 32'h3333);
            check("bp_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_result", 32'(result), 32'h0002);
        check("bp_second_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'b0010);
        exp_q.push_back({16'h0002, 4'b0010});
        recv(0, 0);

        // Reset during a multiply
        send(4'(MUL), 16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_output", 32'(out_valid), 32'd0);
        exp_q.push_back({16'h0002, 4'b0000});
        send(4'(ADD), 16'h0001, 16'h0001);
        recv(0, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] rx, ry;
            ro = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            case ($urandom_range(0, 5))
                0:       rx = 16'h7FFF;
                1:       rx = 16'h8000;
                2:       rx = 16'hFFFF;
                default: rx = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       ry = 16'h0000;
                1:       ry = 16'h0001;
                2:       ry = 16'hFFFF;
                default: ry = W'($urandom);
            endcase
            exp_q.push_back(model(ro, rx, ry));
            send(ro, rx, ry);
            recv((ro == 4'(MUL)) ? W : 0, $urandom_range(0, 3));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
